// File: rtl/clk_div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // All-ones value of a w-bit counter; widths above 32 are not supported.
    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/clk_div_monitor_sync.sv
// sync_edge_det: multi-flop synchronizer for an async level plus rising-edge detect.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a divided clock and compares the period to an expected value.
// Define CLK_DIV_MON_CONT_EN for continuous mode (re-measure every period until timeout).
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             start,
    input  logic [CNT_W-1:0] expected_period,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             match,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ALL1 = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);

    logic             s, rise;
    state_t           state;
    logic [CNT_W-1:0] cnt, hi, exp_q;
    logic [CNT_W:0]   diff;
    logic             in_tol;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (div_in),
        .s    (s),
        .rise (rise)
    );

    // One extra bit so the absolute difference never wraps.
    always_comb begin
        diff = ({1'b0, cnt} >= {1'b0, exp_q}) ? ({1'b0, cnt} - {1'b0, exp_q})
                                              : ({1'b0, exp_q} - {1'b0, cnt});
        in_tol = (diff <= TOL_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            period    <= '0;
            high_time <= '0;
            match     <= 1'b0;
            timeout   <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            exp_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        busy    <= 1'b1;
                        exp_q   <= expected_period;
                        cnt     <= '0;
                        hi      <= '0;
                        timeout <= 1'b0;
                        match   <= 1'b0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= CNT_W'(1);
                        hi    <= CNT_W'(1);
                    end else if (cnt == CNT_ALL1) begin
                        period    <= CNT_ALL1;
                        high_time <= hi;
                        timeout   <= 1'b1;
                        match     <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period    <= cnt;
                        high_time <= hi;
                        match     <= in_tol;
                        done      <= 1'b1;
`ifdef CLK_DIV_MON_CONT_EN
                        // The terminating edge opens the next measurement.
                        cnt       <= CNT_W'(1);
                        hi        <= CNT_W'(1);
`else
                        state     <= IDLE;
                        busy      <= 1'b0;
`endif
                    end else if (cnt == CNT_ALL1) begin
                        period    <= CNT_ALL1;
                        high_time <= hi;
                        timeout   <= 1'b1;
                        match     <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        hi  <= hi + CNT_W'(s);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
